// File: rtl/rsa_pkg.sv
// rsa_pkg: shared width, FSM states and counter width for the RSA datapath blocks
package rsa_pkg;
    localparam int RSA_WIDTH = 512;
    localparam int RSA_CNT_W = $clog2(RSA_WIDTH + 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
endpackage

// File: rtl/rsa_mulacc_if.sv
// rsa_mulacc_if: request operands (start/x/y/m) in, product halves, modulus and status (busy/done/range_err) out
interface rsa_mulacc_if
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] prod_hi;
    logic [WIDTH-1:0] prod_lo;
    logic [WIDTH-1:0] m_out;
    logic             busy;
    logic             done;
    logic             range_err;
    modport master (output start, x, y, m, input prod_hi, prod_lo, m_out, busy, done, range_err);
    modport slave (input start, x, y, m, output prod_hi, prod_lo, m_out, busy, done, range_err);
endinterface

// File: rtl/rsa_mulacc.sv
// rsa_mulacc: shift-add WIDTH x WIDTH multiplier feeding the modular-reduction divider; ports clk, rst, bus (rsa_mulacc_if.slave)
module rsa_mulacc
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH
) (
    input logic         clk,
    input logic         rst,
    rsa_mulacc_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [WIDTH:0]   sum;
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        mcand_d  = mcand_q;
        m_d      = m_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        sum      = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
        case (state_q)
            IDLE: if (bus.start) begin
                state_d  = RUN;
                mcand_d  = bus.x;
                mplier_d = bus.y;
                m_d      = bus.m;
                acc_d    = '0;
                cnt_d    = CW'(WIDTH);
                err_d    = bus.m == '0 || bus.x >= bus.m || bus.y >= bus.m;
            end
            RUN: begin
                // carry enters acc top, acc lsb drops into the vacated multiplier msb
                acc_d    = sum[WIDTH:1];
                mplier_d = {sum[0], mplier_q[WIDTH-1:1]};
                cnt_d    = cnt_q - CW'(1);
                state_d  = cnt_q == CW'(1) ? DONE : RUN;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mplier_q <= '0;
            mcand_q  <= '0;
            m_q      <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            mcand_q  <= mcand_d;
            m_q      <= m_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end
    assign bus.prod_hi   = acc_q;
    assign bus.prod_lo   = mplier_q;
    assign bus.m_out     = m_q;
    assign bus.busy      = state_q != IDLE;
    assign bus.done      = state_q == DONE;
    assign bus.range_err = err_q;
endmodule
